dmem_resp: RTL and testbench
============================

# dmem_resp

Memory-stage load/store responder for the RV64 pipeline. It accepts the execute stage's data-memory request (enable, write, address, store data, funct3), checks alignment, builds byte strobes and replicated store data, and runs one transaction on a 64-bit req/gnt/rvalid data bus. It returns sign- or zero-extended load data and stalls the pipeline through `mem_ready` until the access completes.

## Interface
- `GNT_TIMEOUT`, default 255: maximum cycles `bus_req` is held without `bus_gnt` before the access faults; 0 disables the timeout.
- `clk` in 1: clock; single clock domain.
- `rst` in 1: reset, synchronous, active-high.
- `req_en` in 1: access request; held by upstream until `mem_ready`.
- `req_write` in 1: 1 = store, 0 = load.
- `req_addr` in 64: byte address.
- `req_wdata` in 64: store data; low bytes are significant.
- `req_funct3` in 3: RISC-V load/store funct3.
- `mem_flush` in 1: abort the current access.
- `mem_ready` out 1: the stage may advance.
- `load_data` out 64: extended load result, valid while `mem_ready` is high in DONE.
- `misalign` out 1: misaligned access, valid with `mem_ready`.
- `access_fault` out 1: bus error, grant timeout, or illegal funct3, valid with `mem_ready`.
- `bus_req` out 1, `bus_we` out 1, `bus_addr` out 64 (`{addr[63:3],3'b0}`), `bus_wstrb` out 8, `bus_wdata` out 64: bus request.
- `bus_gnt` in 1, `bus_rvalid` in 1, `bus_rdata` in 64, `bus_err` in 1: bus response. `rvalid` acknowledges both loads and stores.

## Operation
- States: IDLE, REQ, WAIT, DONE, DRAIN.
- **IDLE**
  - `!req_en`: `mem_ready`=1 and the state stays IDLE.
  - `req_en && !mem_flush`: latch all request fields, `mem_ready`=0.
  - A bad request goes to DONE with no bus activity. Bad means funct3=111 (sets `access_fault`) or misaligned (sets `misalign`).
  - Any other request goes to REQ.
- **Alignment rule:** size is taken from `funct3[1:0]`. Half requires `addr[0]`=0. Word requires `addr[1:0]`=0. Double requires `addr[2:0]`=0.
- **REQ**
  - `bus_req`=1 with all bus fields stable.
  - `bus_gnt` goes to WAIT.
  - `mem_flush` without grant goes to IDLE, and `bus_req` drops the next cycle.
  - The grant counter reaching `GNT_TIMEOUT` goes to DONE with `access_fault`=1.
  - When `bus_gnt` and `mem_flush` arrive in the same cycle, the grant wins and the state goes to DRAIN.
- **WAIT**
  - `bus_req`=0.
  - `bus_rvalid` goes to DONE and captures the response. On `bus_err`, `access_fault`=1 and `load_data`=0.
  - `mem_flush` goes to DRAIN.
- **DRAIN:** wait for `bus_rvalid`, discard the response, go to IDLE. No `mem_ready` pulse is produced. A granted store is not cancelled.
- **DONE:** `mem_ready`=1 for exactly one cycle with the result outputs, then IDLE. `mem_flush` in DONE suppresses nothing.
- **Strobe:** `bus_wstrb` = (byte 0x01, half 0x03, word 0x0F, double 0xFF) << `addr[2:0]`. Loads drive the same strobe.
- **Store data:** `bus_wdata` replicates the low byte x8, the low half x4, or the low word x2; double is passed as-is.
- **Load data:** `r = bus_rdata >> (addr[2:0]*8)`.
  - Sign-extend `r` to 64 bits for funct3 000/001/010.
  - Zero-extend `r` for funct3 100/101/110.
  - Use `r` directly for 011.
- **Store results:** `load_data`=0.
- **Result outputs:** `load_data`, `misalign` and `access_fault` are registered. They are cleared on entering REQ and held through DONE.

## Timing
- **Reset:** state=IDLE, `bus_req`=0, `bus_we`=0, `bus_wstrb`=0, `bus_wdata`=0, `bus_addr`=0, `load_data`=0, `misalign`=0, `access_fault`=0, counter=0. `mem_ready` is forced to 0 while `rst`=1.
- `rst` asserted in any state, including WAIT and DRAIN, returns to IDLE the next cycle. The bus agent is reset together with this block.
- **Nominal access:** request seen at cycle T; `bus_req` high at T+1. With `bus_gnt` at T+1 and `bus_rvalid` at T+2, `mem_ready` is high at T+3 (3-cycle stall).
- Each extra gnt or rvalid wait cycle adds one cycle of stall.
- **Misaligned or illegal request:** `mem_ready` at T+1.
- **No-access cycles:** `mem_ready` is combinationally 1 in IDLE with `!req_en`, with zero latency.
- DONE always returns to IDLE, so one bubble separates back-to-back accesses. The next request is sampled at T+4.
- **Grant counter:** resets on entering REQ and increments each REQ cycle without `bus_gnt`. The timeout fires on the cycle the count equals `GNT_TIMEOUT`.

## Test plan
- **Aligned load:** LD at 0x1000 with rdata=0x8877665544332211, gnt at T+1, rvalid at T+2 -> `mem_ready` at T+3 with `load_data`=0x8877665544332211.
- **LB with sign extension:** LB at 0x1003 with rdata byte 3 = 0x80 -> `bus_wstrb`=0x08 and `load_data`=0xFFFFFFFFFFFFFF80. The same access as LBU -> `load_data`=0x80.
- **SH replication:** SH at 0x2006 with wdata=0x1234 -> `bus_we`=1, `bus_wstrb`=0xC0, `bus_wdata`=0x1234123412341234.
- **Misaligned:** SW at 0x2002 -> `mem_ready` at T+1 with `misalign`=1 and `bus_req` never asserted.
- **Flush:** flush in REQ with no gnt -> back to IDLE with no `mem_ready` pulse. Flush in WAIT -> DRAIN consumes the later rvalid and produces no `mem_ready`.
- **Timeout and bus error:** `GNT_TIMEOUT`=4 with gnt held low -> `access_fault`=1 at T+5. `bus_err` with rvalid -> `access_fault`=1 and `load_data`=0.

Source files
------------

// File: rtl/dmem_resp_if.sv
// Pipeline-side load/store request/response and 64-bit req/gnt/rvalid data bus
// seen by the memory-stage responder (slave) and its driver (master).
interface dmem_resp_if;
  logic        req_en;
  logic        req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        mem_flush;
  logic        mem_ready;
  logic [63:0] load_data;
  logic        misalign;
  logic        access_fault;
  logic        bus_req;
  logic        bus_we;
  logic [63:0] bus_addr;
  logic [7:0]  bus_wstrb;
  logic [63:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [63:0] bus_rdata;
  logic        bus_err;

  modport slave (
    input  req_en, req_write, req_addr, req_wdata, req_funct3, mem_flush,
    input  bus_gnt, bus_rvalid, bus_rdata, bus_err,
    output mem_ready, load_data, misalign, access_fault,
    output bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata
  );

  modport master (
    output req_en, req_write, req_addr, req_wdata, req_funct3, mem_flush,
    output bus_gnt, bus_rvalid, bus_rdata, bus_err,
    input  mem_ready, load_data, misalign, access_fault,
    input  bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata
  );
endinterface

// File: rtl/dmem_resp.sv
// RV64 memory-stage load/store responder: alignment check, strobe/replication,
// one req/gnt/rvalid bus transaction per access, load extension and stall.
module dmem_resp #(
  parameter int GNT_TIMEOUT = 255
) (
  input logic        clk,
  input logic        rst,
  dmem_resp_if.slave io
);
  localparam int CW = (GNT_TIMEOUT < 2) ? 1 : $clog2(GNT_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, DRAIN} state_t;

  typedef struct packed {
    logic       write;
    logic [2:0] funct3;
    logic [2:0] off;
  } req_t;

  state_t        state;
  req_t          rq;
  logic [CW-1:0] gnt_cnt;

  logic [2:0]  off;
  logic        mis;
  logic        ill;
  logic [7:0]  strb;
  logic [63:0] wrep;
  logic [63:0] shr;
  logic [63:0] ext;
  logic        to_hit;

  always_comb begin
    off  = io.req_addr[2:0];
    ill  = (io.req_funct3 == 3'b111);
    mis  = 1'b0;
    strb = 8'h00;
    wrep = io.req_wdata;
    case (io.req_funct3[1:0])
      2'b00: begin mis = 1'b0;     strb = 8'h01 << off; wrep = {8{io.req_wdata[7:0]}};  end
      2'b01: begin mis = off[0];   strb = 8'h03 << off; wrep = {4{io.req_wdata[15:0]}}; end
      2'b10: begin mis = |off[1:0]; strb = 8'h0F << off; wrep = {2{io.req_wdata[31:0]}}; end
      default: begin mis = |off;   strb = 8'hFF << off; wrep = io.req_wdata;            end
    endcase
  end

  // Right-align the addressed bytes, then extend according to the latched funct3.
  always_comb begin
    shr = io.bus_rdata >> {rq.off, 3'b000};
    case (rq.funct3)
      3'b000:  ext = {{56{shr[7]}},  shr[7:0]};
      3'b001:  ext = {{48{shr[15]}}, shr[15:0]};
      3'b010:  ext = {{32{shr[31]}}, shr[31:0]};
      3'b011:  ext = shr;
      3'b100:  ext = {56'd0, shr[7:0]};
      3'b101:  ext = {48'd0, shr[15:0]};
      3'b110:  ext = {32'd0, shr[31:0]};
      default: ext = '0;
    endcase
  end

  // Fires on the REQ cycle whose missing grant would make the count reach the limit.
  assign to_hit = (GNT_TIMEOUT != 0) && ((int'(gnt_cnt) + 1) == GNT_TIMEOUT);

  assign io.mem_ready = !rst && (((state == IDLE) && !io.req_en) || (state == DONE));

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      rq              <= '0;
      gnt_cnt         <= '0;
      io.bus_req      <= 1'b0;
      io.bus_we       <= 1'b0;
      io.bus_addr     <= '0;
      io.bus_wstrb    <= '0;
      io.bus_wdata    <= '0;
      io.load_data    <= '0;
      io.misalign     <= 1'b0;
      io.access_fault <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (io.req_en && !io.mem_flush) begin
            rq <= '{write: io.req_write, funct3: io.req_funct3, off: off};
            if (mis || ill) begin
              io.misalign     <= mis;
              io.access_fault <= ill;
              io.load_data    <= '0;
              state           <= DONE;
            end else begin
              io.bus_req      <= 1'b1;
              io.bus_we       <= io.req_write;
              io.bus_addr     <= {io.req_addr[63:3], 3'b000};
              io.bus_wstrb    <= strb;
              io.bus_wdata    <= wrep;
              io.load_data    <= '0;
              io.misalign     <= 1'b0;
              io.access_fault <= 1'b0;
              gnt_cnt         <= '0;
              state           <= REQ;
            end
          end
        end
        REQ: begin
          if (io.bus_gnt) begin
            io.bus_req <= 1'b0;
            state      <= io.mem_flush ? DRAIN : WAIT;
          end else if (io.mem_flush) begin
            io.bus_req <= 1'b0;
            state      <= IDLE;
          end else if (to_hit) begin
            io.bus_req      <= 1'b0;
            io.access_fault <= 1'b1;
            state           <= DONE;
          end else if (GNT_TIMEOUT != 0) begin
            gnt_cnt <= gnt_cnt + 1'b1;
          end
        end
        WAIT: begin
          if (io.bus_rvalid) begin
            io.access_fault <= io.bus_err;
            io.load_data    <= (io.bus_err || rq.write) ? 64'd0 : ext;
            state           <= DONE;
          end else if (io.mem_flush) begin
            state <= DRAIN;
          end
        end
        DRAIN: if (io.bus_rvalid) state <= IDLE;
        DONE:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_resp.sv
// Self-checking bench for dmem_resp: directed scenarios plus randomized accesses
// checked against an arithmetic reference of the load/store rules.
module tb_dmem_resp;
  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  dmem_resp_if io();

  dmem_resp #(.GNT_TIMEOUT(4)) dut (.clk(clk), .rst(rst), .io(io.slave));

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic [63:0] exp_load(input logic [2:0] f3, input logic [63:0] addr,
                                           input logic [63:0] rdata);
    int n = nbytes(f3);
    logic [63:0] r, mask;
    r = rdata >> (8 * int'(addr[2:0]));
    if (n == 8) return r;
    mask = (64'd1 << (8 * n)) - 64'd1;
    r = r & mask;
    if (!f3[2] && r[8*n-1]) r = r | ~mask;
    return r;
  endfunction

  function automatic logic [7:0] exp_strb(input logic [2:0] f3, input logic [63:0] addr);
    int n = nbytes(f3);
    logic [15:0] s;
    s = 16'(((1 << n) - 1) << int'(addr[2:0]));
    return s[7:0];
  endfunction

  function automatic logic [63:0] exp_wdata(input logic [2:0] f3, input logic [63:0] wdata);
    int n = nbytes(f3);
    logic [63:0] o;
    for (int i = 0; i < 8; i++) o[8*i +: 8] = wdata[8*(i % n) +: 8];
    return o;
  endfunction

  // One complete access; starts in IDLE, or in DONE of a chained previous access.
  task automatic do_access(input string nm, input bit wr, input logic [63:0] addr,
                           input logic [63:0] wdata, input logic [2:0] f3,
                           input logic [63:0] rdata, input bit err, input int gd,
                           input int rd, input bit from_done, input bit chain);
    int          n     = nbytes(f3);
    bit          mis_e = (int'(addr[2:0]) % n) != 0;
    bit          ill_e = (f3 == 3'b111);
    logic [63:0] ld_e;
    ld_e = (err || wr || ill_e) ? 64'd0 : exp_load(f3, addr, rdata);
    io.req_en = 1'b1; io.req_write = wr; io.req_addr = addr;
    io.req_wdata = wdata; io.req_funct3 = f3; io.mem_flush = 1'b0;
    if (from_done) begin
      step;
      tests++;
      if ({io.mem_ready, io.bus_req} !== 2'b00) begin
        fails++; $display("FAIL %s.bubble: ready/req=%b want 00", nm, {io.mem_ready, io.bus_req});
      end
    end
    step;
    if (mis_e || ill_e) begin
      tests++;
      if ({io.mem_ready, io.misalign, io.access_fault, io.bus_req} !== {1'b1, mis_e, ill_e, 1'b0}
          || io.load_data !== 64'd0) begin
        fails++;
        $display("FAIL %s.bad: rdy/mis/flt/req=%b ld=%h want %b ld=0", nm,
                 {io.mem_ready, io.misalign, io.access_fault, io.bus_req}, io.load_data,
                 {1'b1, mis_e, ill_e, 1'b0});
      end
    end else begin
      tests++;
      if (io.bus_req !== 1'b1 || io.bus_we !== wr || io.mem_ready !== 1'b0 ||
          io.bus_addr !== {addr[63:3], 3'b000} || io.bus_wstrb !== exp_strb(f3, addr)) begin
        fails++;
        $display("FAIL %s.req: req=%b we=%b rdy=%b addr=%h strb=%h want 1 %b 0 %h %h", nm,
                 io.bus_req, io.bus_we, io.mem_ready, io.bus_addr, io.bus_wstrb, wr,
                 {addr[63:3], 3'b000}, exp_strb(f3, addr));
      end
      if (wr) begin
        tests++;
        if (io.bus_wdata !== exp_wdata(f3, wdata)) begin
          fails++; $display("FAIL %s.wdata: got %h want %h", nm, io.bus_wdata, exp_wdata(f3, wdata));
        end
      end
      tests++;
      if ({io.misalign, io.access_fault, io.load_data} !== 66'd0) begin
        fails++; $display("FAIL %s.clear: mis=%b flt=%b ld=%h want all 0", nm,
                          io.misalign, io.access_fault, io.load_data);
      end
      for (int i = 0; i < gd; i++) begin
        step;
        tests++;
        if ({io.bus_req, io.mem_ready} !== 2'b10) begin
          fails++; $display("FAIL %s.gntwait: req/rdy=%b want 10", nm, {io.bus_req, io.mem_ready});
        end
      end
      io.bus_gnt = 1'b1;
      step;
      io.bus_gnt = 1'b0;
      tests++;
      if ({io.bus_req, io.mem_ready} !== 2'b00) begin
        fails++; $display("FAIL %s.wait: req/rdy=%b want 00", nm, {io.bus_req, io.mem_ready});
      end
      for (int i = 0; i < rd; i++) begin
        step;
        tests++;
        if (io.mem_ready !== 1'b0) begin
          fails++; $display("FAIL %s.rvwait: rdy=%b want 0", nm, io.mem_ready);
        end
      end
      io.bus_rvalid = 1'b1; io.bus_rdata = rdata; io.bus_err = err;
      step;
      io.bus_rvalid = 1'b0; io.bus_err = 1'b0; io.bus_rdata = {$urandom, $urandom};
      tests++;
      if (io.mem_ready !== 1'b1 || io.load_data !== ld_e || io.misalign !== 1'b0 ||
          io.access_fault !== err) begin
        fails++;
        $display("FAIL %s.done: rdy=%b ld=%h mis=%b flt=%b want 1 %h 0 %b", nm,
                 io.mem_ready, io.load_data, io.misalign, io.access_fault, ld_e, err);
      end
    end
    if (!chain) begin
      io.req_en = 1'b0;
      step;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step; step;
    tests++;
    if ({io.mem_ready, io.bus_req, io.bus_we, io.misalign, io.access_fault} !== 5'b0 ||
        io.bus_wstrb !== 8'h00 || io.bus_wdata !== 64'd0 || io.bus_addr !== 64'd0 ||
        io.load_data !== 64'd0) begin
      fails++;
      $display("FAIL reset: rdy/req/we/mis/flt=%b strb=%h wd=%h addr=%h ld=%h want all 0",
               {io.mem_ready, io.bus_req, io.bus_we, io.misalign, io.access_fault},
               io.bus_wstrb, io.bus_wdata, io.bus_addr, io.load_data);
    end
    rst = 1'b0;
    step;
    tests++;
    if (io.mem_ready !== 1'b1) begin
      fails++; $display("FAIL idle_ready: rdy=%b want 1", io.mem_ready);
    end
  endtask

  task automatic test_loads;
    do_access("ld",  1'b0, 64'h1000, 64'd0, 3'b011, 64'h8877665544332211, 1'b0, 0, 0, 1'b0, 1'b0);
    do_access("lb",  1'b0, 64'h1003, 64'd0, 3'b000, 64'h7766554480332211, 1'b0, 0, 0, 1'b0, 1'b0);
    do_access("lbu", 1'b0, 64'h1003, 64'd0, 3'b100, 64'h7766554480332211, 1'b0, 0, 0, 1'b0, 1'b0);
    do_access("lw_slow", 1'b0, 64'h1004, 64'd0, 3'b010, 64'h89ABCDEF01234567, 1'b0, 3, 2, 1'b0, 1'b0);
  endtask

  task automatic test_stores;
    do_access("sh", 1'b1, 64'h2006, 64'h1234, 3'b001, 64'hFFFF, 1'b0, 0, 0, 1'b0, 1'b0);
    do_access("sw_mis", 1'b1, 64'h2002, 64'hDEADBEEF, 3'b010, 64'd0, 1'b0, 0, 0, 1'b0, 1'b0);
    do_access("ill", 1'b0, 64'h2000, 64'd0, 3'b111, 64'd0, 1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_flush_req;
    io.req_en = 1'b1; io.req_write = 1'b0; io.req_addr = 64'h3000;
    io.req_funct3 = 3'b010; io.mem_flush = 1'b0;
    step;
    io.mem_flush = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step;
      tests++;
      if ({io.bus_req, io.mem_ready} !== 2'b00) begin
        fails++; $display("FAIL flush_req: req/rdy=%b want 00", {io.bus_req, io.mem_ready});
      end
    end
    io.mem_flush = 1'b0;
    do_access("after_flush_req", 1'b0, 64'h3000, 64'd0, 3'b010, 64'h0000000080000000,
              1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_flush_wait(input bit with_gnt);
    io.req_en = 1'b1; io.req_write = 1'b1; io.req_addr = 64'h4000;
    io.req_wdata = 64'h55; io.req_funct3 = 3'b011; io.mem_flush = 1'b0;
    step;
    io.bus_gnt = 1'b1;
    io.mem_flush = with_gnt;
    step;
    io.bus_gnt = 1'b0;
    io.mem_flush = !with_gnt;
    if (!with_gnt) step;
    io.mem_flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tests++;
      if ({io.bus_req, io.mem_ready} !== 2'b00) begin
        fails++; $display("FAIL drain: req/rdy=%b want 00", {io.bus_req, io.mem_ready});
      end
      step;
    end
    io.bus_rvalid = 1'b1;
    step;
    io.bus_rvalid = 1'b0;
    tests++;
    if ({io.bus_req, io.mem_ready} !== 2'b00) begin
      fails++; $display("FAIL drain_exit: req/rdy=%b want 00", {io.bus_req, io.mem_ready});
    end
    do_access("after_drain", 1'b0, 64'h4002, 64'd0, 3'b101, 64'h00000000ABCD0000,
              1'b0, 1, 1, 1'b0, 1'b0);
  endtask

  task automatic test_timeout_err;
    io.req_en = 1'b1; io.req_write = 1'b0; io.req_addr = 64'h5000;
    io.req_funct3 = 3'b011; io.mem_flush = 1'b0;
    step;
    for (int i = 1; i <= 4; i++) begin
      tests++;
      if ({io.bus_req, io.mem_ready} !== 2'b10) begin
        fails++; $display("FAIL timeout_wait%0d: req/rdy=%b want 10", i, {io.bus_req, io.mem_ready});
      end
      step;
    end
    tests++;
    if ({io.mem_ready, io.access_fault, io.misalign, io.bus_req} !== 4'b1100) begin
      fails++; $display("FAIL timeout: rdy/flt/mis/req=%b want 1100",
                        {io.mem_ready, io.access_fault, io.misalign, io.bus_req});
    end
    io.req_en = 1'b0;
    step;
    do_access("bus_err", 1'b0, 64'h5008, 64'd0, 3'b011, 64'h1122334455667788, 1'b1, 0, 1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid;
    io.req_en = 1'b1; io.req_write = 1'b0; io.req_addr = 64'h6000;
    io.req_funct3 = 3'b011; io.mem_flush = 1'b0;
    step;
    io.bus_gnt = 1'b1;
    step;
    io.bus_gnt = 1'b0;
    io.req_en = 1'b0;
    rst = 1'b1;
    #1;
    tests++;
    if (io.mem_ready !== 1'b0) begin
      fails++; $display("FAIL rst_ready: rdy=%b want 0", io.mem_ready);
    end
    step;
    rst = 1'b0;
    #1;
    tests++;
    if ({io.mem_ready, io.bus_req} !== 2'b10) begin
      fails++; $display("FAIL rst_mid: rdy/req=%b want 10", {io.mem_ready, io.bus_req});
    end
    step;
  endtask

  task automatic test_back_to_back;
    do_access("b2b_a", 1'b0, 64'h7001, 64'd0, 3'b000, 64'h000000000000FF00, 1'b0, 0, 0, 1'b0, 1'b1);
    do_access("b2b_b", 1'b1, 64'h7004, 64'hCAFEF00D, 3'b010, 64'd0, 1'b0, 1, 0, 1'b1, 1'b0);
  endtask

  task automatic test_random;
    bit prev_chain = 1'b0;
    for (int k = 0; k < 150; k++) begin
      bit          wr = 1'($urandom_range(0, 1));
      logic [2:0]  f3;
      logic [63:0] a  = {$urandom, $urandom};
      int          n;
      bit          ch = (k != 149) && ($urandom_range(0, 2) == 0);
      if (wr) begin
        int s = $urandom_range(0, 4);
        f3 = (s == 4) ? 3'b111 : 3'(s);
      end else begin
        f3 = 3'($urandom_range(0, 7));
      end
      n = nbytes(f3);
      if ($urandom_range(0, 3) != 0) a[2:0] = 3'(int'(a[2:0]) / n * n);
      do_access($sformatf("rnd%0d", k), wr, a, {$urandom, $urandom}, f3, {$urandom, $urandom},
                ($urandom_range(0, 9) == 0), $urandom_range(0, 3), $urandom_range(0, 3),
                prev_chain, ch);
      prev_chain = ch;
    end
  endtask

  initial begin
    io.req_en = 1'b0; io.req_write = 1'b0; io.req_addr = '0; io.req_wdata = '0;
    io.req_funct3 = '0; io.mem_flush = 1'b0; io.bus_gnt = 1'b0; io.bus_rvalid = 1'b0;
    io.bus_rdata = '0; io.bus_err = 1'b0;
    rst = 1'b1;
    test_reset;
    test_loads;
    test_stores;
    test_flush_req;
    test_flush_wait(1'b0);
    test_flush_wait(1'b1);
    test_timeout_err;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end
endmodule
